// File: rtl/if_pc_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, imem request handshake, IF/ID register with skid buffer.
// Optional perf counters (stall/flush cycles) are enabled by defining IF_PERF_CNT_EN.
module if_pc_fetch_stage #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      PC_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] next_pc,
    output logic [WIDTH-1:0] pc_plus4,
    input  logic             stall,
    input  logic             flush,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [WIDTH-1:0] if_id_pc4,
    output logic [WIDTH-1:0] if_id_instr,
    output logic             if_id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    localparam logic [1:0]       S_BOOT  = 2'd0;
    localparam logic [1:0]       S_FETCH = 2'd1;
    localparam logic [1:0]       S_HOLD  = 2'd2;
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(PC_STEP);

    logic [1:0]       state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             kill_q, kill_d;
    logic [WIDTH-1:0] redir_q, redir_d;
    logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [WIDTH-1:0] id_pc_q, id_pc_d;
    logic [WIDTH-1:0] id_pc4_q, id_pc4_d;
    logic [WIDTH-1:0] id_instr_q, id_instr_d;
    logic             id_valid_q, id_valid_d;

    assign pc_plus4    = pc_q + STEP;
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_pc4   = id_pc4_q;
    assign if_id_instr = id_instr_q;
    assign if_id_valid = id_valid_q;

    // Next-state and datapath control; flush outranks stall, kill drops the in-flight response.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        redir_d      = redir_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        id_instr_d   = id_instr_q;
        id_valid_d   = id_valid_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (flush) begin
                    id_valid_d   = 1'b0;
                    skid_pc_d    = '0;
                    skid_instr_d = '0;
                    if (imem_ready) begin
                        pc_d   = next_pc;
                        kill_d = 1'b0;
                    end else begin
                        redir_d = next_pc;
                        kill_d  = 1'b1;
                    end
                end else if (!imem_ready) begin
                    if (!stall) id_valid_d = 1'b0;
                end else if (kill_q) begin
                    pc_d   = redir_q;
                    kill_d = 1'b0;
                    if (!stall) id_valid_d = 1'b0;
                end else if (stall) begin
                    skid_pc_d    = pc_q;
                    skid_instr_d = imem_rdata;
                    state_d      = S_HOLD;
                end else begin
                    id_pc_d    = pc_q;
                    id_pc4_d   = pc_q + STEP;
                    id_instr_d = imem_rdata;
                    id_valid_d = 1'b1;
                    pc_d       = next_pc;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    id_valid_d   = 1'b0;
                    skid_pc_d    = '0;
                    skid_instr_d = '0;
                    pc_d         = next_pc;
                    state_d      = S_FETCH;
                end else if (!stall) begin
                    id_pc_d      = skid_pc_q;
                    id_pc4_d     = skid_pc_q + STEP;
                    id_instr_d   = skid_instr_q;
                    id_valid_d   = 1'b1;
                    skid_pc_d    = '0;
                    skid_instr_d = '0;
                    pc_d         = next_pc;
                    state_d      = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
        req_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            req_q        <= 1'b0;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            redir_q      <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            id_pc_q      <= '0;
            id_pc4_q     <= '0;
            id_instr_q   <= '0;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            redir_q      <= redir_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            id_instr_q   <= id_instr_d;
            id_valid_q   <= id_valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; the BOOT cycle is not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != S_BOOT) begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
            if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_pc_fetch_stage.sv
// Testbench for if_pc_fetch_stage: directed vector table, hand sequences, random run vs. behavioural model.
module tb_if_pc_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    if_pc_fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (RST_PC),
        .PC_STEP  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc     (next_pc),
        .pc_plus4    (pc_plus4),
        .stall       (stall),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks what the fetch stage is doing in terms of fetches, parked data and redirects.
    bit          m_live;
    bit          m_booting;
    bit          m_parked;
    bit          m_squash;
    logic [31:0] m_pc, m_target, m_park_pc, m_park_ins;
    logic [31:0] m_id_pc, m_id_pc4, m_id_ins;
    bit          m_id_v;
    int unsigned m_stalls, m_flushes;

    function automatic void deliver(input logic [31:0] pc, input logic [31:0] ins);
        m_id_pc  = pc;
        m_id_pc4 = pc + 32'd4;
        m_id_ins = ins;
        m_id_v   = 1'b1;
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            m_live = 1; m_booting = 1; m_parked = 0; m_squash = 0;
            m_pc = RST_PC; m_id_pc = 0; m_id_pc4 = 0; m_id_ins = 0; m_id_v = 0;
            m_stalls = 0; m_flushes = 0;
            return;
        end
        if (!m_live) return;
        if (m_booting) begin
            m_booting = 0;
            return;
        end
        if (stall) m_stalls++;
        if (flush) m_flushes++;
        if (m_parked) begin
            if (flush) begin
                m_id_v = 0; m_parked = 0; m_pc = next_pc;
            end else if (!stall) begin
                deliver(m_park_pc, m_park_ins);
                m_parked = 0; m_pc = next_pc;
            end
            return;
        end
        if (flush) begin
            m_id_v = 0;
            if (imem_ready) begin
                m_pc = next_pc; m_squash = 0;
            end else begin
                m_squash = 1; m_target = next_pc;
            end
        end else if (!imem_ready) begin
            if (!stall) m_id_v = 0;
        end else if (m_squash) begin
            m_pc = m_target; m_squash = 0;
            if (!stall) m_id_v = 0;
        end else if (stall) begin
            m_parked = 1; m_park_pc = m_pc; m_park_ins = imem_rdata;
        end else begin
            deliver(m_pc, imem_rdata);
            m_pc = next_pc;
        end
    endfunction

    task automatic check_model();
        check("m_req",      imem_req,    32'(!m_booting && !m_parked));
        check("m_addr",     imem_addr,   m_pc);
        check("m_pc_plus4", pc_plus4,    m_pc + 32'd4);
        check("m_valid",    if_id_valid, 32'(m_id_v));
        check("m_id_pc",    if_id_pc,    m_id_pc);
        check("m_id_pc4",   if_id_pc4,   m_id_pc4);
        check("m_id_instr", if_id_instr, m_id_ins);
`ifdef IF_PERF_CNT_EN
        check("m_stall_cnt", perf_stall_cnt, m_stalls);
        check("m_flush_cnt", perf_flush_cnt, m_flushes);
`endif
    endtask

    task automatic drive(input bit r, input bit s, input bit f, input bit rd,
                         input logic [31:0] data, input logic [31:0] npc);
        rst_n = r; stall = s; flush = f; imem_ready = rd; imem_rdata = data; next_pc = npc;
    endtask

    // One clock: model check at negedge, model update on the edge, return 1 time unit after it.
    task automatic tick();
        @(negedge clk);
        if (m_live) check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        bit          chk;
        bit          rst_n, stall, flush, rdy;
        logic [31:0] rdata, npc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    function automatic vec_t mk(input bit c, input bit r, input bit s, input bit f, input bit rd,
                                input logic [31:0] data, input logic [31:0] npc,
                                input bit eq, input logic [31:0] ea, input bit ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.chk = c; v.rst_n = r; v.stall = s; v.flush = f; v.rdy = rd;
        v.rdata = data; v.npc = npc;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    vec_t tbl[30];

    initial begin
        logic [31:0] i0, i1, i2, i3, i4, i5, i6, i7, i8, i9, i10, i11;
        i0 = 32'h1000_0000; i1 = 32'h1000_0001; i2 = 32'h1000_0002; i3 = 32'h2000_0010;
        i4 = 32'h2000_0020; i5 = 32'h2000_0024; i6 = 32'h3000_0100; i7 = 32'h3000_0104;
        i8 = 32'h3000_0200; i9 = 32'h4000_0204; i10 = 32'h4000_FFFC; i11 = 32'h5000_0500;
        m_live = 0;
        drive(0, 0, 0, 0, 0, 0);

        // Expected outputs are those seen during the cycle, before the edge that consumes the row.
        //             chk rst st fl rdy rdata          npc           req addr          v  if_id_pc      instr
        tbl[0]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
        tbl[1]  = mk(1, 1, 1, 1, 1, 32'hDEAD_BEEF, 32'h999,       0, RST_PC,        0, 32'h0,         32'h0);
        tbl[2]  = mk(1, 1, 0, 0, 1, i0,            32'h0040_0004, 1, RST_PC,        0, 32'h0,         32'h0);
        tbl[3]  = mk(1, 1, 0, 0, 1, i1,            32'h0040_0008, 1, 32'h0040_0004, 1, RST_PC,        i0);
        tbl[4]  = mk(1, 1, 0, 0, 1, i2,            32'h10,        1, 32'h0040_0008, 1, 32'h0040_0004, i1);
        tbl[5]  = mk(1, 1, 0, 0, 0, 32'h0,         32'h14,        1, 32'h10,        1, 32'h0040_0008, i2);
        tbl[6]  = mk(1, 1, 0, 0, 0, 32'h0,         32'h14,        1, 32'h10,        0, 32'h0040_0008, i2);
        tbl[7]  = mk(1, 1, 0, 0, 0, 32'h0,         32'h14,        1, 32'h10,        0, 32'h0040_0008, i2);
        tbl[8]  = mk(1, 1, 0, 0, 1, i3,            32'h20,        1, 32'h10,        0, 32'h0040_0008, i2);
        tbl[9]  = mk(1, 1, 1, 0, 1, i4,            32'h24,        1, 32'h20,        1, 32'h10,        i3);
        tbl[10] = mk(1, 1, 1, 0, 0, 32'h0,         32'h24,        0, 32'h20,        1, 32'h10,        i3);
        tbl[11] = mk(1, 1, 0, 0, 0, 32'h0,         32'h24,        0, 32'h20,        1, 32'h10,        i3);
        tbl[12] = mk(1, 1, 0, 0, 1, i5,            32'h30,        1, 32'h24,        1, 32'h20,        i4);
        tbl[13] = mk(1, 1, 0, 1, 0, 32'h0,         32'h100,       1, 32'h30,        1, 32'h24,        i5);
        tbl[14] = mk(1, 1, 0, 0, 0, 32'h0,         32'h555,       1, 32'h30,        0, 32'h24,        i5);
        tbl[15] = mk(1, 1, 0, 0, 1, 32'hBAD0_0030, 32'h777,       1, 32'h30,        0, 32'h24,        i5);
        tbl[16] = mk(1, 1, 0, 0, 1, i6,            32'h104,       1, 32'h100,       0, 32'h24,        i5);
        tbl[17] = mk(1, 1, 1, 0, 1, i7,            32'h108,       1, 32'h104,       1, 32'h100,       i6);
        tbl[18] = mk(1, 1, 1, 1, 0, 32'h0,         32'h200,       0, 32'h104,       1, 32'h100,       i6);
        tbl[19] = mk(1, 1, 0, 0, 1, i8,            32'h204,       1, 32'h200,       0, 32'h100,       i6);
        tbl[20] = mk(1, 1, 0, 0, 1, i9,            32'hFFFF_FFFC, 1, 32'h204,       1, 32'h200,       i8);
        tbl[21] = mk(1, 1, 0, 0, 1, i10,           32'h0,         1, 32'hFFFF_FFFC, 1, 32'h204,       i9);
        tbl[22] = mk(1, 1, 0, 0, 0, 32'h0,         32'h4,         1, 32'h0,         1, 32'hFFFF_FFFC, i10);
        tbl[23] = mk(1, 1, 0, 1, 1, 32'hBAD,       32'h300,       1, 32'h0,         0, 32'hFFFF_FFFC, i10);
        tbl[24] = mk(1, 1, 0, 1, 0, 32'h0,         32'h400,       1, 32'h300,       0, 32'hFFFF_FFFC, i10);
        tbl[25] = mk(1, 1, 0, 1, 0, 32'h0,         32'h500,       1, 32'h300,       0, 32'hFFFF_FFFC, i10);
        tbl[26] = mk(1, 1, 0, 0, 1, 32'hBAD1,      32'h999,       1, 32'h300,       0, 32'hFFFF_FFFC, i10);
        tbl[27] = mk(1, 1, 0, 0, 1, i11,           32'h504,       1, 32'h500,       0, 32'hFFFF_FFFC, i10);
        tbl[28] = mk(1, 0, 0, 0, 0, 32'h0,         32'h0,         1, 32'h504,       1, 32'h500,       i11);
        tbl[29] = mk(1, 1, 0, 0, 1, 32'h1234,      32'h0,         0, RST_PC,        0, 32'h0,         32'h0);

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst_n, tbl[i].stall, tbl[i].flush, tbl[i].rdy, tbl[i].rdata, tbl[i].npc);
            @(negedge clk);
            if (m_live) check_model();
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_req", i),      imem_req,    32'(tbl[i].e_req));
                check($sformatf("tbl%0d_addr", i),     imem_addr,   tbl[i].e_addr);
                check($sformatf("tbl%0d_pc_plus4", i), pc_plus4,    tbl[i].e_addr + 32'd4);
                check($sformatf("tbl%0d_valid", i),    if_id_valid, 32'(tbl[i].e_valid));
                check($sformatf("tbl%0d_id_pc", i),    if_id_pc,    tbl[i].e_pc);
                check($sformatf("tbl%0d_instr", i),    if_id_instr, tbl[i].e_instr);
            end
            @(posedge clk);
            model_edge();
            #1;
        end

        // Hand sequence: stalls/flushes while a request waits, then a squashed response and a redirect.
        drive(0, 0, 0, 0, 0, 0);            tick();
        drive(1, 1, 1, 0, 0, 32'h40);       tick();
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 0, 0, 32'h44);   tick();
        end
        drive(1, 0, 1, 0, 0, 32'h60);       tick();
        drive(1, 0, 1, 0, 0, 32'h80);       tick();
        check("hs_addr_held", imem_addr,   RST_PC);
        check("hs_valid_fl",  if_id_valid, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("hs_stall_cnt", perf_stall_cnt, 32'd5);
        check("hs_flush_cnt", perf_flush_cnt, 32'd2);
`endif
        drive(1, 0, 0, 1, 32'hBAD2, 32'h999); tick();
        check("hs_redirect",  imem_addr,   32'h80);
        check("hs_dropped",   if_id_valid, 32'h0);

        // Zero-wait burst: one instruction per cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 1, 32'hA0 + 32'(k), 32'h84 + 32'(4 * k)); tick();
            check($sformatf("hs_burst%0d_valid", k), if_id_valid, 32'h1);
            check($sformatf("hs_burst%0d_pc", k),    if_id_pc,    32'h80 + 32'(4 * k));
            check($sformatf("hs_burst%0d_pc4", k),   if_id_pc4,   32'h84 + 32'(4 * k));
        end

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] npc;
            npc = ($urandom_range(3) != 0) ? (m_pc + 32'd4) : $urandom;
            drive($urandom_range(99) != 0, $urandom_range(3) == 0, $urandom_range(9) == 0,
                  $urandom_range(9) < 6, $urandom, npc);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
